cond_branch_unit: RTL and testbench

- Consumes the Z/N/V status flags produced by the datapath ALU and owns the architectural status register.
- Resolves conditional branches (B, BEQ, BNE, BLT, BLE) against that register.
- Interlocks branches behind outstanding compares and returns a registered taken/target result to the controller over a valid/ready handshake.
- Sits between the ALU flag outputs and the PC-select logic of the RISC machine.

---
 rtl/cond_branch_unit_if.sv | 30 +++
 rtl/cond_branch_unit.sv | 185 ++++++++++++++++++
 tb/tb_cond_branch_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_branch_unit_if.sv
// Branch request / response channel between the controller and cond_branch_unit.
// The controller (master) issues branch requests and consumes resolved results;
// the branch unit (slave) accepts requests and returns taken/target.
interface cond_branch_unit_if #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned OFF_W = 8
);
  // request channel
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_cond;
  logic [PC_W-1:0]  br_pc;
  logic [OFF_W-1:0] br_off;

  // response channel
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_taken;
  logic [PC_W-1:0]  resp_target;

  modport master (
    output br_valid, br_cond, br_pc, br_off, resp_ready,
    input  br_ready, resp_valid, resp_taken, resp_target
  );

  modport slave (
    input  br_valid, br_cond, br_pc, br_off, resp_ready,
    output br_ready, resp_valid, resp_taken, resp_target
  );
endinterface

// File: rtl/cond_branch_unit.sv
// Conditional branch resolution unit.
// Owns the architectural Z/N/V status register, tracks compares whose flags
// have not yet been written back, holds a branch until no compare is
// outstanding, then returns a registered taken/target result.
module cond_branch_unit #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmp_issue,
  input  logic            flag_load,
  input  logic            Z_in,
  input  logic            N_in,
  input  logic            V_in,
  cond_branch_unit_if.slave br_if,
  output logic            Z_out,
  output logic            N_out,
  output logic            V_out,
  output logic            pending,
  output logic            err
);

  // branch condition encodings
  localparam logic [2:0] COND_B   = 3'b000;
  localparam logic [2:0] COND_BEQ = 3'b001;
  localparam logic [2:0] COND_BNE = 3'b010;
  localparam logic [2:0] COND_BLT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state;

  // status register {Z,N,V}
  logic             z_q, n_q, v_q;

  // outstanding compare counter
  logic [CNT_W-1:0] count;

  // captured request
  logic [2:0]       cond_q;
  logic [PC_W-1:0]  pc_q;
  logic [OFF_W-1:0] off_q;

  // registered handshake outputs
  logic             br_ready_q;
  logic             resp_valid_q;
  logic             resp_taken_q;
  logic [PC_W-1:0]  resp_target_q;

  // combinational evaluation of the captured branch
  logic             lt;
  logic             taken_c;
  logic             illegal_c;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  target_c;

  // error sources
  logic             cnt_ovf;
  logic             resolve;
  logic             eval_bad;

  // Status register: load on flag_load, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (flag_load) begin
      z_q <= Z_in;
      n_q <= N_in;
      v_q <= V_in;
    end
  end

  assign Z_out = z_q;
  assign N_out = n_q;
  assign V_out = v_q;

  // Outstanding-compare counter: issue increments, flag write-back
  // decrements, both together cancel; saturates at the top value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({cmp_issue, flag_load})
        2'b10: if (count != '1) count <= count + CNT_W'(1);
        2'b01: if (count != '0) count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign pending = (count != '0);

  // Condition evaluation against the registered flags.
  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    lt        = n_q ^ v_q;
    case (cond_q)
      COND_B:   taken_c = 1'b1;
      COND_BEQ: taken_c = z_q;
      COND_BNE: taken_c = ~z_q;
      COND_BLT: taken_c = lt;
      COND_BLE: taken_c = lt | z_q;
      default:  illegal_c = 1'b1;
    endcase
  end

  // Target: sign-extended offset added modulo 2^PC_W.
  assign off_ext  = PC_W'($signed(off_q));
  assign target_c = taken_c ? (pc_q + off_ext) : pc_q;

  assign resolve  = (state == WAIT) && (count == '0);
  assign eval_bad = resolve && illegal_c;
  assign cnt_ovf  = cmp_issue && !flag_load && (count == '1);

  // Sticky error: counter overflow or an illegal condition code at resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (cnt_ovf || eval_bad) begin
      err <= 1'b1;
    end
  end

  // Request/response FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cond_q        <= '0;
      pc_q          <= '0;
      off_q         <= '0;
      br_ready_q    <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_taken_q  <= 1'b0;
      resp_target_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (br_if.br_valid) begin
            cond_q     <= br_if.br_cond;
            pc_q       <= br_if.br_pc;
            off_q      <= br_if.br_off;
            br_ready_q <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (resolve) begin
            resp_taken_q  <= taken_c;
            resp_target_q <= target_c;
            resp_valid_q  <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (br_if.resp_ready) begin
            resp_valid_q <= 1'b0;
            br_ready_q   <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          br_ready_q   <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign br_if.br_ready    = br_ready_q;
  assign br_if.resp_valid  = resp_valid_q;
  assign br_if.resp_taken  = resp_taken_q;
  assign br_if.resp_target = resp_target_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed testbench for cond_branch_unit: hand-computed vectors covering
// flag loading, every condition code, offset wrap, compare interlock,
// counter saturation, response back-pressure and asynchronous reset.
module tb_cond_branch_unit;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned OFF_W = 8;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst_n;
  logic cmp_issue;
  logic flag_load;
  logic z_in, n_in, v_in;
  logic z_out, n_out, v_out;
  logic pending;
  logic err;

  int errors;
  int checks;

  cond_branch_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bif ();

  cond_branch_unit #(
    .PC_W (PC_W),
    .OFF_W(OFF_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .cmp_issue(cmp_issue),
    .flag_load(flag_load),
    .Z_in     (z_in),
    .N_in     (n_in),
    .V_in     (v_in),
    .br_if    (bif),
    .Z_out    (z_out),
    .N_out    (n_out),
    .V_out    (v_out),
    .pending  (pending),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic z, input logic n, input logic v);
    flag_load = 1'b1;
    z_in = z;
    n_in = n;
    v_in = v;
    step();
    flag_load = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [2:0] cond,
                        input logic [PC_W-1:0] pc, input logic [OFF_W-1:0] off);
    check({tag, ".ready"}, 32'(bif.br_ready), 32'd1);
    bif.br_valid = 1'b1;
    bif.br_cond  = cond;
    bif.br_pc    = pc;
    bif.br_off   = off;
    step();
    bif.br_valid = 1'b0;
    check({tag, ".lat"}, 32'(bif.resp_valid), 32'd0);
  endtask

  task automatic consume(input string tag);
    bif.resp_ready = 1'b1;
    step();
    bif.resp_ready = 1'b0;
    check({tag, ".done"}, 32'(bif.resp_valid), 32'd0);
    check({tag, ".rdy"}, 32'(bif.br_ready), 32'd1);
  endtask

  // full branch with no outstanding compare: result one edge after accept
  task automatic run_branch(input string tag, input logic [2:0] cond,
                            input logic [PC_W-1:0] pc, input logic [OFF_W-1:0] off,
                            input logic exp_taken, input logic [PC_W-1:0] exp_target);
    accept(tag, cond, pc, off);
    step();
    check({tag, ".valid"}, 32'(bif.resp_valid), 32'd1);
    check({tag, ".taken"}, 32'(bif.resp_taken), 32'(exp_taken));
    check({tag, ".target"}, 32'(bif.resp_target), 32'(exp_target));
    check({tag, ".busy"}, 32'(bif.br_ready), 32'd0);
    consume(tag);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    cmp_issue      = 1'b0;
    flag_load      = 1'b0;
    z_in           = 1'b0;
    n_in           = 1'b0;
    v_in           = 1'b0;
    bif.br_valid   = 1'b0;
    bif.br_cond    = '0;
    bif.br_pc      = '0;
    bif.br_off     = '0;
    bif.resp_ready = 1'b0;

    // reset state
    step();
    step();
    check("rst.valid", 32'(bif.resp_valid), 32'd0);
    check("rst.taken", 32'(bif.resp_taken), 32'd0);
    check("rst.target", 32'(bif.resp_target), 32'd0);
    check("rst.flags", 32'({z_out, n_out, v_out}), 32'd0);
    check("rst.pending", 32'(pending), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst.ready", 32'(bif.br_ready), 32'd1);

    // BEQ taken with Z=1
    load_flags(1'b1, 1'b0, 1'b0);
    check("flags.z", 32'({z_out, n_out, v_out}), 32'b100);
    run_branch("beq", 3'b001, 9'h010, 8'h05, 1'b1, 9'h015);
    // BNE not taken with Z=1
    run_branch("bne", 3'b010, 9'h020, 8'hFE, 1'b0, 9'h020);
    // unconditional, negative offset wraps below zero
    run_branch("b_wrap", 3'b000, 9'h001, 8'hFE, 1'b1, 9'h1FF);
    // positive offset wraps past the top
    run_branch("b_wrap2", 3'b000, 9'h1F0, 8'h20, 1'b1, 9'h010);

    // signed less-than variants
    load_flags(1'b0, 1'b1, 1'b1);
    run_branch("blt_nv", 3'b011, 9'h030, 8'h04, 1'b0, 9'h030);
    run_branch("ble_nv", 3'b100, 9'h030, 8'h04, 1'b0, 9'h030);
    load_flags(1'b0, 1'b1, 1'b0);
    run_branch("blt_n", 3'b011, 9'h030, 8'h04, 1'b1, 9'h034);
    run_branch("ble_n", 3'b100, 9'h040, 8'h10, 1'b1, 9'h050);
    load_flags(1'b0, 1'b0, 1'b1);
    run_branch("blt_v", 3'b011, 9'h030, 8'hFC, 1'b1, 9'h02C);
    load_flags(1'b1, 1'b0, 1'b0);
    run_branch("ble_z", 3'b100, 9'h040, 8'h7F, 1'b1, 9'h0BF);
    run_branch("blt_z", 3'b011, 9'h040, 8'h7F, 1'b0, 9'h040);
    load_flags(1'b0, 1'b0, 1'b0);
    run_branch("ble_0", 3'b100, 9'h040, 8'h7F, 1'b0, 9'h040);
    run_branch("beq_0", 3'b001, 9'h040, 8'h80, 1'b0, 9'h040);
    run_branch("bne_0", 3'b010, 9'h100, 8'h80, 1'b1, 9'h080);

    // interlock behind one outstanding compare
    cmp_issue = 1'b1;
    step();
    cmp_issue = 1'b0;
    check("lock.pending", 32'(pending), 32'd1);
    accept("lock", 3'b001, 9'h050, 8'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock.hold", 32'(bif.resp_valid), 32'd0);
      check("lock.busy", 32'(bif.br_ready), 32'd0);
    end
    load_flags(1'b1, 1'b0, 1'b0);
    check("lock.wb", 32'(bif.resp_valid), 32'd0);
    check("lock.clear", 32'(pending), 32'd0);
    step();
    check("lock.valid", 32'(bif.resp_valid), 32'd1);
    check("lock.taken", 32'(bif.resp_taken), 32'd1);
    check("lock.target", 32'(bif.resp_target), 32'h060);
    consume("lock");

    // simultaneous issue and write-back leaves count at one
    cmp_issue = 1'b1;
    step();
    flag_load = 1'b1;
    z_in = 1'b0;
    n_in = 1'b1;
    v_in = 1'b0;
    step();
    cmp_issue = 1'b0;
    flag_load = 1'b0;
    check("both.pending", 32'(pending), 32'd1);
    check("both.flags", 32'({z_out, n_out, v_out}), 32'b010);
    load_flags(1'b0, 1'b0, 1'b1);
    check("both.drain", 32'(pending), 32'd0);
    // write-back with nothing outstanding: flags load, no error
    load_flags(1'b1, 1'b1, 1'b0);
    check("idle_wb.pending", 32'(pending), 32'd0);
    check("idle_wb.flags", 32'({z_out, n_out, v_out}), 32'b110);
    check("idle_wb.err", 32'(err), 32'd0);

    // illegal condition code
    run_branch("ill", 3'b110, 9'h070, 8'h03, 1'b0, 9'h070);
    check("ill.err", 32'(err), 32'd1);
    step();
    check("ill.sticky", 32'(err), 32'd1);

    // reset clears sticky error
    rst_n = 1'b0;
    #1;
    check("rst2.err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // counter saturation at three
    cmp_issue = 1'b1;
    step();
    step();
    step();
    check("sat.err3", 32'(err), 32'd0);
    step();
    cmp_issue = 1'b0;
    check("sat.err", 32'(err), 32'd1);
    check("sat.pending", 32'(pending), 32'd1);
    load_flags(1'b0, 1'b0, 1'b0);
    load_flags(1'b0, 1'b0, 1'b0);
    check("sat.two", 32'(pending), 32'd1);
    load_flags(1'b0, 1'b0, 1'b0);
    check("sat.zero", 32'(pending), 32'd0);

    // back-pressure: result held, no new request accepted
    accept("bp", 3'b000, 9'h100, 8'h20);
    step();
    check("bp.valid", 32'(bif.resp_valid), 32'd1);
    bif.br_valid = 1'b1;
    bif.br_cond  = 3'b010;
    bif.br_pc    = 9'h1AA;
    bif.br_off   = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp.hold_valid", 32'(bif.resp_valid), 32'd1);
      check("bp.hold_taken", 32'(bif.resp_taken), 32'd1);
      check("bp.hold_target", 32'(bif.resp_target), 32'h120);
      check("bp.hold_ready", 32'(bif.br_ready), 32'd0);
    end
    bif.br_valid = 1'b0;
    consume("bp");
    step();
    check("bp.no_extra", 32'(bif.resp_valid), 32'd0);

    // asynchronous reset in the middle of WAIT
    load_flags(1'b1, 1'b1, 1'b1);
    cmp_issue = 1'b1;
    step();
    cmp_issue = 1'b0;
    accept("arst", 3'b001, 9'h0A0, 8'h01);
    step();
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(bif.resp_valid), 32'd0);
    check("arst.flags", 32'({z_out, n_out, v_out}), 32'd0);
    check("arst.pending", 32'(pending), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("arst.ready", 32'(bif.br_ready), 32'd1);
    step();
    check("arst.discard", 32'(bif.resp_valid), 32'd0);
    check("arst.ready2", 32'(bif.br_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog so the run always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
